// File: rtl/spork_pkg.sv
// Shared types and default widths for the program-counter sequencer.
package spork_pkg;

  localparam int unsigned PC_W_DEF      = 16;
  localparam int unsigned OFF_W_DEF     = 8;
  localparam int unsigned LUT_DEPTH_DEF = 16;
  localparam int unsigned CNT_W         = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  typedef logic [PC_W_DEF-1:0] pc_t;

endpackage

// File: rtl/jump_lut.sv
// Jump-target register file: one write port, one combinational read port.
// Reads return the pre-write value when both hit the same entry in one cycle.
module jump_lut #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter scheduler: restart, stall, halt, table jump, relative branch
// or increment each cycle, plus run status and a saturating retire count.
module pc_sequencer
  import spork_pkg::*;
#(
  parameter int unsigned PC_W      = PC_W_DEF,
  parameter int unsigned OFF_W     = OFF_W_DEF,
  parameter int unsigned LUT_DEPTH = LUT_DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         stall,
  input  logic                         halt_req,
  input  logic                         jump,
  input  logic [$clog2(LUT_DEPTH)-1:0] jump_sel,
  input  logic                         branch,
  input  logic [OFF_W-1:0]             offset,
  input  logic                         cfg_we,
  input  logic [$clog2(LUT_DEPTH)-1:0] cfg_addr,
  input  logic [PC_W-1:0]              cfg_data,
  output logic [PC_W-1:0]              pc,
  output logic                         pc_valid,
  output logic                         busy,
  output logic                         done,
  output logic [CNT_W-1:0]             instr_count
);

  state_t            state, state_nxt;
  logic [PC_W-1:0]   pc_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              done_nxt;
  logic [PC_W-1:0]   jump_target;
  logic [PC_W-1:0]   off_ext;
  logic [CNT_W-1:0]  cnt_inc;

  jump_lut #(
    .DEPTH (LUT_DEPTH),
    .WIDTH (PC_W)
  ) u_jump_lut (
    .clk   (clk),
    .reset (reset),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (jump_sel),
    .rdata (jump_target)
  );

  assign off_ext = PC_W'($signed(offset));
  assign cnt_inc = (instr_count == '1) ? instr_count : instr_count + CNT_W'(1);

  // Next-state / next-PC selection; priority start > stall > halt > jump > branch.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cnt_nxt   = instr_count;
    done_nxt  = 1'b0;
    case (state)
      IDLE, HALTED: begin
        if (start) begin
          state_nxt = RUN;
          pc_nxt    = '0;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        if (start) begin
          pc_nxt  = '0;
          cnt_nxt = '0;
        end else if (stall) begin
          pc_nxt = pc;
        end else if (halt_req) begin
          state_nxt = HALTED;
          cnt_nxt   = cnt_inc;
          done_nxt  = 1'b1;
        end else if (jump) begin
          pc_nxt  = jump_target;
          cnt_nxt = cnt_inc;
        end else if (branch) begin
          pc_nxt  = pc + off_ext;
          cnt_nxt = cnt_inc;
        end else begin
          pc_nxt  = pc + PC_W'(1);
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        state_nxt = IDLE;
        pc_nxt    = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= '0;
      instr_count <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      instr_count <= cnt_nxt;
      busy        <= (state_nxt == RUN);
      done        <= done_nxt;
    end
  end

  assign pc_valid = (state == RUN) && !stall;

endmodule

// File: tb/tb_pc_sequencer.sv
// Vector-table bench for pc_sequencer with a queue of expected post-edge results.
module tb_pc_sequencer;
  import spork_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, stall, halt_req, jump, branch, cfg_we;
  logic [3:0]  jump_sel, cfg_addr;
  logic [7:0]  offset;
  logic [15:0] cfg_data;
  pc_t         pc;
  logic        pc_valid, busy, done;
  logic [15:0] instr_count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        st, sl, hr, jp, br, we;
    logic [3:0]  sel, wa;
    logic [7:0]  off;
    logic [15:0] wd;
    logic        vld;
    logic [15:0] epc;
    logic        ebusy, edone;
    logic [15:0] ecnt;
  } vec_t;

  typedef struct {
    int          idx;
    logic [15:0] pc;
    logic        busy, done;
    logic [15:0] cnt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  pc_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt_req(halt_req),
    .jump(jump), .jump_sel(jump_sel), .branch(branch), .offset(offset),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .pc(pc), .pc_valid(pc_valid), .busy(busy), .done(done), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  function automatic vec_t V(input logic st, input logic sl, input logic hr,
                             input logic jp, input logic [3:0] sel, input logic br,
                             input logic [7:0] off, input logic we, input logic [3:0] wa,
                             input logic [15:0] wd, input logic vld, input logic [15:0] epc,
                             input logic eb, input logic ed, input logic [15:0] ec);
    vec_t v;
    v.st = st; v.sl = sl; v.hr = hr; v.jp = jp; v.sel = sel; v.br = br;
    v.off = off; v.we = we; v.wa = wa; v.wd = wd; v.vld = vld;
    v.epc = epc; v.ebusy = eb; v.edone = ed; v.ecnt = ec;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
    end
  endtask

  task automatic apply(input int idx, input vec_t v);
    exp_t e;
    exp_t o;
    @(negedge clk);
    start = v.st; stall = v.sl; halt_req = v.hr; jump = v.jp; jump_sel = v.sel;
    branch = v.br; offset = v.off; cfg_we = v.we; cfg_addr = v.wa; cfg_data = v.wd;
    #1;
    check("pc_valid", idx, 32'(pc_valid), 32'(v.vld));
    e.idx = idx; e.pc = v.epc; e.busy = v.ebusy; e.done = v.edone; e.cnt = v.ecnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    o = sb.pop_front();
    check("pc", o.idx, 32'(pc), 32'(o.pc));
    check("busy", o.idx, 32'(busy), 32'(o.busy));
    check("done", o.idx, 32'(done), 32'(o.done));
    check("instr_count", o.idx, 32'(instr_count), 32'(o.cnt));
  endtask

  task automatic check_reset_values(input int idx);
    check("rst_pc", idx, 32'(pc), 32'h0);
    check("rst_busy", idx, 32'(busy), 32'h0);
    check("rst_done", idx, 32'(done), 32'h0);
    check("rst_count", idx, 32'(instr_count), 32'h0);
    check("rst_pc_valid", idx, 32'(pc_valid), 32'h0);
  endtask

  initial begin
    reset = 1'b0;
    start = 0; stall = 0; halt_req = 0; jump = 0; branch = 0; cfg_we = 0;
    jump_sel = '0; cfg_addr = '0; offset = '0; cfg_data = '0;

    // Program table, start, five free cycles
    vecs.push_back(V(0,0,0,0,4'd0,0,8'h00, 1,4'd3,16'h0040, 0, 16'h0000,0,0,16'd0));
    vecs.push_back(V(1,0,0,0,4'd0,0,8'h00, 0,4'd0,16'h0000, 0, 16'h0000,1,0,16'd0));
    for (int i = 1; i <= 5; i++)
      vecs.push_back(V(0,0,0,0,4'd0,0,8'h00, 0,4'd0,16'h0000, 1, 16'(i),1,0,16'(i)));
    // Restart, jump at pc=2, same-cycle write/jump collision
    vecs.push_back(V(1,0,0,0,4'd0,0,8'h00, 0,4'd0,16'h0000, 1, 16'h0000,1,0,16'd0));
    vecs.push_back(V(0,0,0,0,4'd0,0,8'h00, 0,4'd0,16'h0000, 1, 16'h0001,1,0,16'd1));
    vecs.push_back(V(0,0,0,0,4'd0,0,8'h00, 0,4'd0,16'h0000, 1, 16'h0002,1,0,16'd2));
    vecs.push_back(V(0,0,0,1,4'd3,0,8'h00, 0,4'd0,16'h0000, 1, 16'h0040,1,0,16'd3));
    vecs.push_back(V(0,0,0,1,4'd3,0,8'h00, 1,4'd3,16'h0080, 1, 16'h0040,1,0,16'd4));
    vecs.push_back(V(0,0,0,0,4'd0,0,8'h00, 0,4'd0,16'h0000, 1, 16'h0041,1,0,16'd5));
    vecs.push_back(V(0,0,0,1,4'd3,0,8'h00, 0,4'd0,16'h0000, 1, 16'h0080,1,0,16'd6));
    // Negative branch from 0x10, positive wrap from 0xFFFE, increment wrap
    vecs.push_back(V(0,0,0,0,4'd0,0,8'h00, 1,4'd5,16'h0010, 1, 16'h0081,1,0,16'd7));
    vecs.push_back(V(0,0,0,1,4'd5,0,8'h00, 0,4'd0,16'h0000, 1, 16'h0010,1,0,16'd8));
    vecs.push_back(V(0,0,0,0,4'd0,1,8'hF8, 0,4'd0,16'h0000, 1, 16'h0008,1,0,16'd9));
    vecs.push_back(V(0,0,0,0,4'd0,0,8'h00, 1,4'd6,16'hFFFE, 1, 16'h0009,1,0,16'd10));
    vecs.push_back(V(0,0,0,1,4'd6,0,8'h00, 0,4'd0,16'h0000, 1, 16'hFFFE,1,0,16'd11));
    vecs.push_back(V(0,0,0,0,4'd0,1,8'h04, 0,4'd0,16'h0000, 1, 16'h0002,1,0,16'd12));
    vecs.push_back(V(0,0,0,0,4'd0,0,8'h00, 1,4'd7,16'hFFFF, 1, 16'h0003,1,0,16'd13));
    vecs.push_back(V(0,0,0,1,4'd7,0,8'h00, 0,4'd0,16'h0000, 1, 16'hFFFF,1,0,16'd14));
    vecs.push_back(V(0,0,0,0,4'd0,0,8'h00, 0,4'd0,16'h0000, 1, 16'h0000,1,0,16'd15));
    vecs.push_back(V(0,0,0,0,4'd0,0,8'h00, 0,4'd0,16'h0000, 1, 16'h0001,1,0,16'd16));
    // Stall beats halt for three cycles, then halt, then ignored inputs while halted
    for (int i = 0; i < 3; i++)
      vecs.push_back(V(0,1,1,0,4'd0,0,8'h00, 0,4'd0,16'h0000, 0, 16'h0001,1,0,16'd16));
    vecs.push_back(V(0,0,1,0,4'd0,0,8'h00, 0,4'd0,16'h0000, 1, 16'h0001,0,1,16'd17));
    vecs.push_back(V(0,0,0,1,4'd3,1,8'h05, 0,4'd0,16'h0000, 0, 16'h0001,0,0,16'd17));
    // Start from HALTED, restart in RUN overriding a branch
    vecs.push_back(V(1,0,0,0,4'd0,0,8'h00, 0,4'd0,16'h0000, 0, 16'h0000,1,0,16'd0));
    vecs.push_back(V(0,0,0,0,4'd0,0,8'h00, 1,4'd8,16'h0033, 1, 16'h0001,1,0,16'd1));
    vecs.push_back(V(0,0,0,1,4'd8,0,8'h00, 0,4'd0,16'h0000, 1, 16'h0033,1,0,16'd2));
    vecs.push_back(V(1,0,0,0,4'd0,1,8'h05, 0,4'd0,16'h0000, 1, 16'h0000,1,0,16'd0));
    vecs.push_back(V(0,0,0,0,4'd0,0,8'h00, 1,4'd9,16'h0021, 1, 16'h0001,1,0,16'd1));
    vecs.push_back(V(0,0,0,1,4'd9,0,8'h00, 0,4'd0,16'h0000, 1, 16'h0021,1,0,16'd2));

    repeat (2) @(posedge clk);
    #1;
    check_reset_values(-1);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

    // Asynchronous reset mid-RUN at pc=0x0021
    check("pre_rst_pc", 100, 32'(pc), 32'h0021);
    #2 reset = 1'b0;
    #1;
    check_reset_values(101);
    @(negedge clk);
    reset = 1'b1;
    apply(102, V(1,0,0,0,4'd0,0,8'h00, 0,4'd0,16'h0000, 0, 16'h0000,1,0,16'd0));
    apply(103, V(0,0,0,0,4'd0,0,8'h00, 0,4'd0,16'h0000, 1, 16'h0001,1,0,16'd1));
    apply(104, V(0,0,0,1,4'd3,0,8'h00, 0,4'd0,16'h0000, 1, 16'h0000,1,0,16'd2));
    apply(105, V(0,0,0,1,4'd9,0,8'h00, 0,4'd0,16'h0000, 1, 16'h0000,1,0,16'd3));

    check("scoreboard_empty", 106, 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Control FSM that owns and sequences the processor's program counter. It replaces ad-hoc start/halt/jump wiring with one scheduler. Each cycle it decides between restart, stall, halt, absolute jump (through a programmable jump-target table), relative branch and sequential increment. It sits between the instruction decoder/memory interface and the fetch path. It also reports run status and a retired-instruction count.

## Interface
- PC_W, 16, program counter width
- OFF_W, 8, signed relative-branch offset width
- LUT_DEPTH, 16, entries in jump-target table (power of two)
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- start  in  1  pulse: (re)start program at address 0
- stall  in  1  hold PC this cycle (memory/hazard wait)
- halt_req  in  1  current instruction is HALT
- jump  in  1  current instruction is absolute jump via table
- jump_sel  in  $clog2(LUT_DEPTH)  table index for jump
- branch  in  1  current instruction is taken relative branch
- offset  in  OFF_W  signed branch offset, relative to current PC
- cfg_we  in  1  jump-table write strobe
- cfg_addr  in  $clog2(LUT_DEPTH)  table write index
- cfg_data  in  PC_W  table write data
- pc  out  PC_W  current fetch address
- pc_valid  out  1  high when state is RUN and stall is low
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse on entry to HALTED
- instr_count  out  16  instructions retired since last start

## Operation
- States: IDLE (after reset), RUN, HALTED.
- IDLE/HALTED + start: next state RUN, pc<=0, instr_count<=0. Other inputs are ignored in IDLE/HALTED, except cfg writes.
- RUN + start: restart. pc<=0, instr_count<=0, remain RUN. Start overrides every other input.
- RUN priority, highest first: start > stall > halt_req > jump > branch > increment.
- stall: pc, state and instr_count hold. Halt, jump and branch that cycle are discarded; the decoder re-presents them.
- halt_req: state<=HALTED, pc holds, instr_count+1, done=1 next cycle.
- jump: pc<=table[jump_sel], instr_count+1.
- branch: pc<=pc + sign_extend(offset) modulo 2^PC_W, instr_count+1.
- otherwise: pc<=pc+1 modulo 2^PC_W (0xFFFF wraps to 0x0000, no flag), instr_count+1.
- instr_count saturates at 0xFFFF.
- Jump table: LUT_DEPTH x PC_W registers, combinational read. cfg writes are accepted in any state.
- A write and a jump to the same index in the same cycle uses the old entry; the new value is visible from the next cycle.
- Reset values: state IDLE, pc 0, pc_valid 0, busy 0, done 0, instr_count 0, all table entries 0.

## Timing
- Decoder inputs are sampled on the same edge that updates pc. The instruction at pc in cycle N selects pc for cycle N+1, giving single-cycle redirect with no bubble.
- start-to-first-valid-pc latency: 1 cycle (pc=0, pc_valid=1 the cycle after start).
- done asserts the cycle after the halt_req edge, for exactly one cycle. busy falls in that same cycle.
- reset asserted mid-RUN immediately (asynchronously) forces the reset values and clears the table. Operation resumes only after reset deasserts and start arrives.
- When stall and halt_req are both high, stall wins and no done is produced.
- All outputs are registered except pc_valid, which is combinational from state and stall.

## Structure
- Shared package `spork_pkg`: state enum typedef (IDLE, RUN, HALTED), PC_W/OFF_W defaults, pc_t typedef.
- Sub-module `jump_lut`: parameterised register file with asynchronous-reset clear, one write port, one combinational read port.
- The top level holds the FSM, PC register, next-PC mux and counter.

## Test plan
- Reset, start, 5 free cycles -> pc 0,1,2,3,4,5; pc_valid=1; instr_count=5.
- Write table[3]=0x0040, then in RUN at pc=2 assert jump with jump_sel=3 -> next pc 0x0040. Same cycle write table[3]=0x0080 with jump -> pc 0x0040, and a later jump_sel=3 -> 0x0080.
- At pc=0x0010, branch offset=0xF8 (-8) -> pc 0x0008. At pc=0xFFFE, offset=+4 -> pc 0x0002. Free run from 0xFFFF -> 0x0000.
- stall high 3 cycles with halt_req also high -> pc, instr_count frozen, pc_valid=0, no done. Stall low with halt_req -> HALTED, done pulse one cycle, busy=0, pc unchanged.
- start while RUN at pc=0x0033 with branch asserted -> pc 0, instr_count 0. start while HALTED -> RUN, pc 0.
- reset low mid-RUN at pc=0x0021 -> immediately pc 0, busy 0, table cleared (jump_sel=3 after restart yields 0x0000).
